// File: rtl/cmp_result_monitor.sv
// ---------------------------------------------------------------------------
// cmp_result_monitor
//
// Registered consumer of a 2-bit magnitude comparator's result flags.
// On each valid strobe it checks that exactly one flag is set. It keeps
// saturating per-outcome event counters and tracks the last good result.
// It also pulses streak_eq when STREAK_LEN consecutive good "equal"
// results have been seen. Runs do not overlap.
//
// Parameters
//   CNT_W       width of each event counter (>= 2)
//   STREAK_LEN  consecutive equal results that fire streak_eq (2..255)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (highest priority)
//   in_valid     comparator flags are meaningful this cycle
//   A_less_B     comparator flag, A < B
//   A_equal_B    comparator flag, A == B
//   A_greater_B  comparator flag, A > B
//   clear        synchronous clear; beats in_valid and drops that sample
//   lt_count     accepted "less" samples, saturating
//   eq_count     accepted "equal" samples, saturating
//   gt_count     accepted "greater" samples, saturating
//   last_result  00 none/invalid, 01 less, 10 equal, 11 greater
//   flag_err     sticky: a valid sample was not exactly one-hot
//   sat          sticky: some counter reached its maximum
//   streak_eq    one-cycle pulse when an equal run completes
// ---------------------------------------------------------------------------
module cmp_result_monitor #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned STREAK_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             A_less_B,
    input  logic             A_equal_B,
    input  logic             A_greater_B,
    input  logic             clear,
    output logic [CNT_W-1:0] lt_count,
    output logic [CNT_W-1:0] eq_count,
    output logic [CNT_W-1:0] gt_count,
    output logic [1:0]       last_result,
    output logic             flag_err,
    output logic             sat,
    output logic             streak_eq
);

    localparam int unsigned RUN_W = (STREAK_LEN > 1) ? $clog2(STREAK_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STREAK_LEN - 1);

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_LT   = 2'b01;
    localparam logic [1:0] RES_EQ   = 2'b10;
    localparam logic [1:0] RES_GT   = 2'b11;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] lt_q, lt_d;
    logic [CNT_W-1:0] eq_q, eq_d;
    logic [CNT_W-1:0] gt_q, gt_d;
    logic [1:0]       last_q, last_d;
    logic             err_q, err_d;
    logic             sat_q, sat_d;
    logic             streak_q, streak_d;
    logic [RUN_W-1:0] run_q, run_d;

    // ------------------------------------------------------------------
    // Sample decode
    // ------------------------------------------------------------------
    logic [2:0] flags;
    logic       good_lt;
    logic       good_eq;
    logic       good_gt;
    logic       bad_sample;
    logic       accept;

    assign flags  = {A_less_B, A_equal_B, A_greater_B};
    // clear drops the sample presented in the same cycle
    assign accept = in_valid && !clear;

    // Classify the flags; anything not exactly one-hot is a bad sample
    always_comb begin
        good_lt    = 1'b0;
        good_eq    = 1'b0;
        good_gt    = 1'b0;
        bad_sample = 1'b0;
        if (accept) begin
            unique case (flags)
                3'b100:  good_lt    = 1'b1;
                3'b010:  good_eq    = 1'b1;
                3'b001:  good_gt    = 1'b1;
                default: bad_sample = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    always_comb begin
        lt_d = lt_q;
        eq_d = eq_q;
        gt_d = gt_q;
        if (clear) begin
            lt_d = '0;
            eq_d = '0;
            gt_d = '0;
        end else begin
            if (good_lt && (lt_q != CNT_MAX)) lt_d = lt_q + CNT_W'(1);
            if (good_eq && (eq_q != CNT_MAX)) eq_d = eq_q + CNT_W'(1);
            if (good_gt && (gt_q != CNT_MAX)) gt_d = gt_q + CNT_W'(1);
        end
    end

    // Sticky saturation flag, set on the edge a counter reaches max
    always_comb begin
        sat_d = sat_q;
        if (clear) begin
            sat_d = 1'b0;
        end else if ((lt_d == CNT_MAX) || (eq_d == CNT_MAX) || (gt_d == CNT_MAX)) begin
            sat_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Last result and sticky error flag
    // ------------------------------------------------------------------
    always_comb begin
        last_d = last_q;
        err_d  = err_q;
        if (clear) begin
            last_d = RES_NONE;
            err_d  = 1'b0;
        end else if (accept) begin
            if (good_lt) begin
                last_d = RES_LT;
            end else if (good_eq) begin
                last_d = RES_EQ;
            end else if (good_gt) begin
                last_d = RES_GT;
            end else begin
                last_d = RES_NONE;
                err_d  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Equal-streak state machine: state is the run length so far
    // ------------------------------------------------------------------
    logic streak_hit;

    // Next-state logic
    always_comb begin
        run_d = run_q;
        if (clear) begin
            run_d = '0;
        end else if (good_eq) begin
            // A completed run restarts from zero so runs never overlap
            run_d = (run_q == RUN_LAST) ? '0 : run_q + RUN_W'(1);
        end else if (good_lt || good_gt || bad_sample) begin
            run_d = '0;
        end
    end

    // Output logic: completing sample of a run
    always_comb begin
        streak_hit = 1'b0;
        if (good_eq && (run_q == RUN_LAST)) begin
            streak_hit = 1'b1;
        end
    end

    // Pulse is registered and lasts one cycle; clear already masks good_eq
    always_comb begin
        streak_d = streak_hit;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            lt_q     <= '0;
            eq_q     <= '0;
            gt_q     <= '0;
            last_q   <= RES_NONE;
            err_q    <= 1'b0;
            sat_q    <= 1'b0;
            streak_q <= 1'b0;
            run_q    <= '0;
        end else begin
            lt_q     <= lt_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            last_q   <= last_d;
            err_q    <= err_d;
            sat_q    <= sat_d;
            streak_q <= streak_d;
            run_q    <= run_d;
        end
    end

    assign lt_count    = lt_q;
    assign eq_count    = eq_q;
    assign gt_count    = gt_q;
    assign last_result = last_q;
    assign flag_err    = err_q;
    assign sat         = sat_q;
    assign streak_eq   = streak_q;

endmodule

// File: tb/tb_cmp_result_monitor.sv
module tb_cmp_result_monitor;

    localparam int unsigned STREAK = 4;

    logic clk = 1'b0;
    logic rst, in_valid, l_i, e_i, g_i, clear;

    logic [7:0] lt0, eq0, gt0;
    logic [1:0] last0;
    logic       err0, sat0, str0;
    logic [1:0] lt1, eq1, gt1;
    logic [1:0] last1;
    logic       err1, sat1, str1;

    int checks = 0;
    int failures = 0;

    // Model state per instance (0: CNT_W=8, 1: CNT_W=2)
    int m_lt[2], m_eq[2], m_gt[2], m_last[2], m_err[2], m_sat[2], m_run[2], m_pulse[2];
    int m_max[2] = '{255, 3};

    always #5 clk = ~clk;

    cmp_result_monitor #(.CNT_W(8), .STREAK_LEN(STREAK)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .A_less_B(l_i), .A_equal_B(e_i), .A_greater_B(g_i), .clear(clear),
        .lt_count(lt0), .eq_count(eq0), .gt_count(gt0), .last_result(last0),
        .flag_err(err0), .sat(sat0), .streak_eq(str0)
    );

    cmp_result_monitor #(.CNT_W(2), .STREAK_LEN(STREAK)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .A_less_B(l_i), .A_equal_B(e_i), .A_greater_B(g_i), .clear(clear),
        .lt_count(lt1), .eq_count(eq1), .gt_count(gt1), .last_result(last1),
        .flag_err(err1), .sat(sat1), .streak_eq(str1)
    );

    // Reference model: one accepted cycle of behaviour, from the rules
    task automatic model_step(input logic v, input logic [2:0] f, input logic c, input logic r);
        for (int i = 0; i < 2; i++) begin
            m_pulse[i] = 0;
            if (r || c) begin
                m_lt[i] = 0; m_eq[i] = 0; m_gt[i] = 0;
                m_last[i] = 0; m_err[i] = 0; m_sat[i] = 0; m_run[i] = 0;
            end else if (v) begin
                if ($countones(f) == 1) begin
                    if (f[2]) begin
                        m_lt[i] = (m_lt[i] < m_max[i]) ? m_lt[i] + 1 : m_lt[i];
                        m_last[i] = 1; m_run[i] = 0;
                    end else if (f[1]) begin
                        m_eq[i] = (m_eq[i] < m_max[i]) ? m_eq[i] + 1 : m_eq[i];
                        m_last[i] = 2;
                        m_run[i] = m_run[i] + 1;
                        if (m_run[i] == STREAK) begin
                            m_pulse[i] = 1;
                            m_run[i] = 0;
                        end
                    end else begin
                        m_gt[i] = (m_gt[i] < m_max[i]) ? m_gt[i] + 1 : m_gt[i];
                        m_last[i] = 3; m_run[i] = 0;
                    end
                    if (m_lt[i] == m_max[i] || m_eq[i] == m_max[i] || m_gt[i] == m_max[i])
                        m_sat[i] = 1;
                end else begin
                    m_err[i] = 1; m_last[i] = 0; m_run[i] = 0;
                end
            end
        end
    endtask

    function automatic logic [28:0] dut_vec(int i);
        if (i == 0) return {lt0, eq0, gt0, last0, err0, sat0, str0};
        return {6'd0, lt1, 6'd0, eq1, 6'd0, gt1, last1, err1, sat1, str1};
    endfunction

    function automatic logic [28:0] mdl_vec(int i);
        return {8'(m_lt[i]), 8'(m_eq[i]), 8'(m_gt[i]), 2'(m_last[i]),
                1'(m_err[i]), 1'(m_sat[i]), 1'(m_pulse[i])};
    endfunction

    // Apply inputs, clock once, advance the model, settle away from the edge
    task automatic step(input logic v, input logic [2:0] f, input logic c, input logic r);
        in_valid = v; {l_i, e_i, g_i} = f; clear = c; rst = r;
        @(posedge clk);
        model_step(v, f, c, r);
        #1;
    endtask

    function automatic logic [2:0] cmp_flags(logic [1:0] a, logic [1:0] b);
        return {a < b, a == b, a > b};
    endfunction

    task automatic test_reset();
        for (int k = 0; k < 2; k++) step(1'b1, 3'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dut_vec(i) !== 29'd0) begin
                failures++;
                $display("FAIL reset_state dut%0d got=%h exp=0", i, dut_vec(i));
            end
        end
        step(1'b1, cmp_flags(2'b00, 2'b01), 1'b0, 1'b0);
        checks++;
        if (lt0 !== 8'd1 || last0 !== 2'b01) begin
            failures++;
            $display("FAIL first_sample got lt=%0d last=%b exp lt=1 last=01", lt0, last0);
        end
    endtask

    task automatic test_sweep();
        logic [1:0] pa[8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3};
        logic [1:0] pb[8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        step(1'b0, 3'b000, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, cmp_flags(pa[k], pb[k]), 1'b0, 1'b0);
            checks++;
            if (dut_vec(0) !== mdl_vec(0)) begin
                failures++;
                $display("FAIL sweep_step%0d got=%h exp=%h", k, dut_vec(0), mdl_vec(0));
            end
        end
        checks++;
        if (lt0 !== 8'd3 || eq0 !== 8'd2 || gt0 !== 8'd3 || err0 !== 1'b0 || last0 !== 2'b10) begin
            failures++;
            $display("FAIL sweep_totals got lt=%0d eq=%0d gt=%0d err=%b last=%b exp 3 2 3 0 10",
                     lt0, eq0, gt0, err0, last0);
        end
    endtask

    task automatic test_streak();
        logic exp_p;
        step(1'b0, 3'b000, 1'b1, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            step(1'b1, (k == 10) ? 3'b001 : 3'b010, 1'b0, 1'b0);
            exp_p = (k == 4 || k == 8 || k == 14);
            checks++;
            if (str0 !== exp_p || str1 !== exp_p) begin
                failures++;
                $display("FAIL streak_pulse_s%0d got=%b/%b exp=%b", k, str0, str1, exp_p);
            end
        end
        checks++;
        if (eq0 !== 8'd13 || gt0 !== 8'd1) begin
            failures++;
            $display("FAIL streak_counts got eq=%0d gt=%0d exp eq=13 gt=1", eq0, gt0);
        end
        step(1'b0, 3'b010, 1'b0, 1'b0);
        checks++;
        if (str0 !== 1'b0) begin
            failures++;
            $display("FAIL streak_idle got=%b exp=0", str0);
        end
    endtask

    task automatic test_errors();
        logic [2:0] f[3] = '{3'b000, 3'b110, 3'b010};
        logic [1:0] el[3] = '{2'b00, 2'b00, 2'b10};
        step(1'b0, 3'b000, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, f[k], 1'b0, 1'b0);
            checks++;
            if (err0 !== 1'b1 || last0 !== el[k] || lt0 !== 8'd0 || gt0 !== 8'd0
                || eq0 !== 8'(k == 2)) begin
                failures++;
                $display("FAIL err_step%0d got err=%b last=%b lt=%0d eq=%0d gt=%0d exp last=%b",
                         k, err0, last0, lt0, eq0, gt0, el[k]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] eg[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        step(1'b0, 3'b000, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 3'b001, 1'b0, 1'b0);
            checks++;
            if (gt1 !== eg[k] || sat1 !== 1'(k >= 2) || gt0 !== 8'(k + 1) || sat0 !== 1'b0) begin
                failures++;
                $display("FAIL sat_step%0d got gt1=%0d sat1=%b gt0=%0d sat0=%b exp gt1=%0d sat1=%b",
                         k, gt1, sat1, gt0, sat0, eg[k], k >= 2);
            end
        end
    endtask

    task automatic test_clear_collision();
        step(1'b0, 3'b000, 1'b1, 1'b0);
        step(1'b1, 3'b100, 1'b0, 1'b0);
        step(1'b0, 3'b111, 1'b0, 1'b0);
        step(1'b0, 3'b001, 1'b0, 1'b0);
        checks++;
        if (lt0 !== 8'd1 || last0 !== 2'b01 || err0 !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold got lt=%0d last=%b err=%b exp 1 01 0", lt0, last0, err0);
        end
        step(1'b1, 3'b100, 1'b0, 1'b0);
        checks++;
        if (lt0 !== 8'd2) begin
            failures++;
            $display("FAIL pre_clear got lt=%0d exp 2", lt0);
        end
        step(1'b1, 3'b100, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dut_vec(i) !== 29'd0) begin
                failures++;
                $display("FAIL clear_collision dut%0d got=%h exp=0", i, dut_vec(i));
            end
        end
        step(1'b1, 3'b100, 1'b0, 1'b0);
        checks++;
        if (lt0 !== 8'd1) begin
            failures++;
            $display("FAIL post_clear got lt=%0d exp 1", lt0);
        end
    endtask

    task automatic test_random();
        logic [2:0] f;
        logic v, c, r;
        for (int k = 0; k < 400; k++) begin
            v = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0, 1, 2, 3: f = 3'b010;
                4:          f = 3'b100;
                5:          f = 3'b001;
                default:    f = 3'($urandom);
            endcase
            c = ($urandom_range(0, 49) == 0);
            r = ($urandom_range(0, 99) == 0);
            step(v, f, c, r);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_vec(i) !== mdl_vec(i)) begin
                    failures++;
                    $display("FAIL random_c%0d_dut%0d got=%h exp=%h", k, i, dut_vec(i), mdl_vec(i));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; {l_i, e_i, g_i} = 3'b000; clear = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_lt[i] = 0; m_eq[i] = 0; m_gt[i] = 0; m_last[i] = 0;
            m_err[i] = 0; m_sat[i] = 0; m_run[i] = 0; m_pulse[i] = 0;
        end
        #2;
        test_reset();
        test_sweep();
        test_streak();
        test_errors();
        test_saturation();
        test_clear_collision();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
